uart_cmd_loader: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 20 ++
 rtl/uart_tx_ser.sv | 69 ++++++
 rtl/uart_cmd_loader.sv | 173 +++++++++++++++++
 tb/tb_uart_cmd_loader.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the command loader: FSM encoding, protocol ASCII
// constants and the nibble-to-hex helper.
package uart_cmd_pkg;

   typedef enum logic [3:0] {
      IDLE, HDR_CMD, HDR_ADR, HDR_CR, HDR_LF, RD_REQ, RD_WAIT,
      DAT, DAT_CR, DAT_LF, END_CMD, END_CR, END_LF, DRAIN
   } state_e;

   localparam logic [7:0] ASCII_CR  = 8'h0D;
   localparam logic [7:0] ASCII_LF  = 8'h0A;
   localparam logic [7:0] ASCII_CMD = 8'h69;
   localparam logic [7:0] ASCII_END = 8'h65;

   // Lowercase hex digit: 0-9 -> '0'..'9', a-f -> 'a'..'f'
   function automatic logic [7:0] nib2asc(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

endpackage

// File: rtl/uart_tx_ser.sv
// 8N1 serializer: start bit, 8 data bits LSB first, stop bit, CLK_DIV clocks
// per bit. Ready in the final stop-bit cycle so frames can abut.
module uart_tx_ser #(
   parameter int CLK_DIV = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       tx,
   output logic       tx_idle
);

   localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [BW-1:0] baud_q, baud_d;
   logic [3:0]    bit_q, bit_d;
   logic [9:0]    sh_q, sh_d;
   logic          act_q, act_d;
   logic          bit_end, last;

   assign bit_end    = (baud_q == BW'(CLK_DIV - 1));
   assign last       = act_q && (bit_q == 4'd9) && bit_end;
   assign byte_ready = !act_q || last;
   assign tx         = sh_q[0];
   assign tx_idle    = !act_q;

   always_comb begin
      baud_d = baud_q;
      bit_d  = bit_q;
      sh_d   = sh_q;
      act_d  = act_q;
      if (byte_valid && byte_ready) begin
         sh_d   = {1'b1, byte_data, 1'b0};
         bit_d  = 4'd0;
         baud_d = '0;
         act_d  = 1'b1;
      end else if (act_q) begin
         if (bit_end) begin
            baud_d = '0;
            if (bit_q == 4'd9) begin
               act_d = 1'b0;
               sh_d  = '1;
            end else begin
               bit_d = bit_q + 4'd1;
               sh_d  = {1'b1, sh_q[9:1]};
            end
         end else begin
            baud_d = baud_q + BW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         baud_q <= '0;
         bit_q  <= 4'd0;
         sh_q   <= '1;
         act_q  <= 1'b0;
      end else begin
         baud_q <= baud_d;
         bit_q  <= bit_d;
         sh_q   <= sh_d;
         act_q  <= act_d;
      end
   end

endmodule

// File: rtl/uart_cmd_loader.sv
// Streams a block of ROM words to the monitor as an ASCII instruction-write
// command ("i<addr>\r\n" <words> "e\r\n") over an 8N1 line.
module uart_cmd_loader
   import uart_cmd_pkg::*;
#(
   parameter int         AWIDTH   = 12,
   parameter int         CNT_W    = 13,
   parameter int         CLK_DIV  = 434,
   parameter logic [7:0] CMD_CHAR = uart_cmd_pkg::ASCII_CMD,
   parameter logic [7:0] END_CHAR = uart_cmd_pkg::ASCII_END
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [29:0]       start_adr,
   input  logic [AWIDTH-1:0] rom_base,
   input  logic [CNT_W-1:0]  word_count,
   output logic [AWIDTH-1:0] rom_radr,
   input  logic [31:0]       rom_rdata,
   output logic              busy,
   output logic              done,
   output logic              tx
);

   state_e            state_q, state_d;
   logic [2:0]        nib_q, nib_d;
   logic [CNT_W-1:0]  words_q, words_d;
   logic [AWIDTH-1:0] idx_q, idx_d, base_q, base_d, radr_q, radr_d;
   logic [31:0]       sh_q, sh_d;
   logic              wait_q, wait_d, busy_q, busy_d, done_q, done_d;
   logic [7:0]        byte_data;
   logic              byte_valid, byte_ready, ser_idle;

   assign rom_radr = radr_q;
   assign busy     = busy_q;
   assign done     = done_q;

   uart_tx_ser #(.CLK_DIV(CLK_DIV)) u_ser (
      .clk        (clk),
      .rst        (rst),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .tx         (tx),
      .tx_idle    (ser_idle)
   );

   always_comb begin
      state_d    = state_q;
      nib_d      = nib_q;
      words_d    = words_q;
      idx_d      = idx_q;
      base_d     = base_q;
      sh_d       = sh_q;
      wait_d     = wait_q;
      radr_d     = radr_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      case (state_q)
         IDLE: if (start && ser_idle) begin
            sh_d    = {start_adr, 2'b00};
            base_d  = rom_base;
            words_d = word_count;
            idx_d   = '0;
            nib_d   = 3'd0;
            state_d = HDR_CMD;
         end
         // busy rises with the first start bit so it spans exactly the frames
         HDR_CMD: begin
            byte_valid = 1'b1;
            byte_data  = CMD_CHAR;
            if (byte_ready) begin
               busy_d  = 1'b1;
               state_d = HDR_ADR;
            end
         end
         HDR_ADR, DAT: begin
            byte_valid = 1'b1;
            byte_data  = nib2asc(sh_q[31:28]);
            if (byte_ready) begin
               sh_d  = {sh_q[27:0], 4'h0};
               nib_d = nib_q + 3'd1;
               if (nib_q == 3'd7) state_d = (state_q == HDR_ADR) ? HDR_CR : DAT_CR;
            end
         end
         HDR_CR, DAT_CR, END_CR: begin
            byte_valid = 1'b1;
            byte_data  = ASCII_CR;
            if (byte_ready)
               state_d = (state_q == HDR_CR) ? HDR_LF : (state_q == DAT_CR) ? DAT_LF : END_LF;
         end
         HDR_LF: begin
            byte_valid = 1'b1;
            byte_data  = ASCII_LF;
            if (byte_ready) state_d = (words_q == '0) ? END_CMD : RD_REQ;
         end
         RD_REQ: begin
            radr_d  = base_q + idx_q;
            wait_d  = 1'b0;
            state_d = RD_WAIT;
         end
         // one spare cycle lets the synchronous ROM present the new word
         RD_WAIT: begin
            if (wait_q) begin
               sh_d    = rom_rdata;
               nib_d   = 3'd0;
               state_d = DAT;
            end else begin
               wait_d = 1'b1;
            end
         end
         DAT_LF: begin
            byte_valid = 1'b1;
            byte_data  = ASCII_LF;
            if (byte_ready) begin
               words_d = words_q - CNT_W'(1);
               if (words_q == CNT_W'(1)) begin
                  state_d = END_CMD;
               end else begin
                  idx_d   = idx_q + AWIDTH'(1);
                  state_d = RD_REQ;
               end
            end
         end
         END_CMD: begin
            byte_valid = 1'b1;
            byte_data  = END_CHAR;
            if (byte_ready) state_d = END_CR;
         end
         END_LF: begin
            byte_valid = 1'b1;
            byte_data  = ASCII_LF;
            if (byte_ready) state_d = DRAIN;
         end
         // ready here means the last stop bit is in its final cycle
         DRAIN: if (byte_ready) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         nib_q   <= 3'd0;
         words_q <= '0;
         idx_q   <= '0;
         base_q  <= '0;
         sh_q    <= '0;
         wait_q  <= 1'b0;
         radr_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         nib_q   <= nib_d;
         words_q <= words_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
         sh_q    <= sh_d;
         wait_q  <= wait_d;
         radr_q  <= radr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_cmd_loader.sv
// Directed bench: decodes the serial line back into bytes and checks streams,
// timing, ROM addressing, ignored restarts and mid-frame reset.
module tb_uart_cmd_loader;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [29:0] start_adr = '0;
   logic [11:0] rom_base = '0;
   logic [12:0] word_count = '0;
   logic [11:0] rom_radr;
   logic [31:0] rom_rdata;
   logic        busy, done, tx;

   logic [7:0]  s_data = 8'h00;
   logic        s_valid = 1'b0;
   logic        s_ready, s_tx, s_idle;

   logic [31:0] rom [0:4095];
   logic [7:0]  rxq [$];
   logic [11:0] radrq [$];
   logic [11:0] radr_prev = '0;
   logic [7:0]  rx_sh = '0;
   int          rx_cnt = -1;
   int          frm_err = 0, busy_cnt = 0, done_cnt = 0;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   uart_cmd_loader #(.CLK_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .start(start), .start_adr(start_adr),
      .rom_base(rom_base), .word_count(word_count), .rom_radr(rom_radr),
      .rom_rdata(rom_rdata), .busy(busy), .done(done), .tx(tx)
   );

   uart_tx_ser #(.CLK_DIV(DIV)) ser (
      .clk(clk), .rst(rst), .byte_data(s_data), .byte_valid(s_valid),
      .byte_ready(s_ready), .tx(s_tx), .tx_idle(s_idle)
   );

   always @(posedge clk) rom_rdata <= rom[rom_radr];

   always @(negedge clk) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (rom_radr !== radr_prev) radrq.push_back(rom_radr);
      radr_prev = rom_radr;
      if (rst) begin
         rx_cnt = -1;
      end else if (rx_cnt < 0) begin
         if (tx === 1'b0) rx_cnt = 0;
      end else begin
         rx_cnt++;
         if (rx_cnt >= DIV + DIV/2 && rx_cnt <= 8*DIV + DIV/2 && rx_cnt % DIV == DIV/2)
            rx_sh = {tx, rx_sh[7:1]};
         if (rx_cnt == 9*DIV + DIV/2) begin
            if (tx !== 1'b1) frm_err++;
            rxq.push_back(rx_sh);
         end
         if (rx_cnt == 10*DIV - 1) rx_cnt = -1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_stream(input string tag, input string exp);
      chk({tag, " len"}, rxq.size(), exp.len());
      for (int i = 0; i < exp.len() && i < rxq.size(); i++)
         chk($sformatf("%s byte%0d", tag, i), {24'h0, rxq[i]}, {24'h0, exp[i]});
      chk({tag, " framing"}, frm_err, 0);
   endtask

   task automatic clear_obs();
      rxq.delete();
      radrq.delete();
      frm_err  = 0;
      busy_cnt = 0;
      done_cnt = 0;
   endtask

   task automatic pulse_start(input logic [29:0] adr, input logic [11:0] base,
                              input logic [12:0] cnt);
      start_adr  = adr;
      rom_base   = base;
      word_count = cnt;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " done seen"}, done, 1'b1);
      repeat (5) @(negedge clk);
   endtask

   initial begin
      logic [0:10] exp_bits;
      rom[12'h000] = 32'hDEADBEEF;
      rom[12'hFFF] = 32'h0BADF00D;
      repeat (3) @(negedge clk);
      chk("rst tx", tx, 1'b1);
      chk("rst busy", busy, 1'b0);
      chk("rst done", done, 1'b0);
      chk("rst radr", rom_radr, 12'h000);
      rst = 1'b0;
      @(negedge clk);

      // serializer waveform for 0x55 followed by an abutting frame
      chk("ser idle", s_idle, 1'b1);
      exp_bits = 11'b01010101010;
      s_valid = 1'b1;
      s_data  = 8'h55;
      @(negedge clk);
      s_data  = 8'h00;
      for (int c = 0; c <= 40; c++) begin
         chk($sformatf("ser tx c%0d", c), s_tx, exp_bits[(c < 40) ? c / 4 : 10]);
         if (c == 39) chk("ser ready last stop", s_ready, 1'b1);
         if (c < 40) @(negedge clk);
      end
      s_valid = 1'b0;

      // one word from ROM[0]
      clear_obs();
      pulse_start(30'h40, 12'h000, 13'd1);
      wait_done("one word");
      chk_stream("one word", "i00000100\015\012deadbeef\015\012e\015\012");
      chk("one word busy cycles", busy_cnt, 960);
      chk("one word done pulses", done_cnt, 1);

      // empty block: header and trailer only, no ROM access
      clear_obs();
      pulse_start(30'h0, 12'h123, 13'd0);
      wait_done("empty");
      chk_stream("empty", "i00000000\015\012e\015\012");
      chk("empty radr untouched", radrq.size(), 0);
      chk("empty busy cycles", busy_cnt, 560);

      // ROM address wraps from 0xFFF to 0x000
      clear_obs();
      pulse_start(30'h3FFFFFFF, 12'hFFF, 13'd2);
      wait_done("wrap");
      chk_stream("wrap", "ifffffffc\015\0120badf00d\015\012deadbeef\015\012e\015\012");
      chk("wrap radr count", radrq.size(), 2);
      if (radrq.size() == 2) begin
         chk("wrap radr first", radrq[0], 12'hFFF);
         chk("wrap radr second", radrq[1], 12'h000);
      end

      // a second start mid-load is ignored
      clear_obs();
      pulse_start(30'h40, 12'h000, 13'd1);
      repeat (100) @(negedge clk);
      chk("restart busy", busy, 1'b1);
      pulse_start(30'h1234, 12'h055, 13'd5);
      wait_done("restart");
      repeat (50) @(negedge clk);
      chk_stream("restart", "i00000100\015\012deadbeef\015\012e\015\012");
      chk("restart done pulses", done_cnt, 1);

      // reset during the third data bit of the first frame ('i' bit2 = 0)
      clear_obs();
      pulse_start(30'h40, 12'h000, 13'd1);
      repeat (14) @(negedge clk);
      chk("pre-reset tx d2", tx, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid rst tx", tx, 1'b1);
      chk("mid rst busy", busy, 1'b0);
      chk("mid rst done", done, 1'b0);
      chk("mid rst radr", rom_radr, 12'h000);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      clear_obs();
      pulse_start(30'h40, 12'h000, 13'd1);
      wait_done("after reset");
      chk_stream("after reset", "i00000100\015\012deadbeef\015\012e\015\012");
      chk("after reset done pulses", done_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
